// File: rtl/pipe_hazard_fwd_unit.sv
// pipe_hazard_fwd_unit
// Hazard detection and operand forwarding for the pipelined CPU, placed beside
// the ID stage. Destination registers of in-flight instructions are tracked in
// a private shadow shift register of FWD_DEPTH post-ID stages (1 = EXE ...
// FWD_DEPTH = WB), so no write-back info has to come back in through ports.
//
// Outputs:
//   fwda/fwdb : 0 = register file, k = result of tracked stage k
//   stall     : hold PC and IF/ID, inject a bubble into EXE
//   if_flush  : squash IF/ID on a taken branch that is not stalled
//   md_busy / md_done : multicycle mul/div scoreboard status
//
// Optional build macro PIPE_HZD_STATS_EN adds free-running 32-bit counters
// stall_cnt (cycles with stall) and fwd_cnt (cycles with any operand forwarded).
module pipe_hazard_fwd_unit #(
  parameter int NREG_BITS  = 5,
  parameter int FWD_DEPTH  = 3,
  parameter int LOAD_STAGE = 2,
  parameter int MD_LATENCY = 4,
  parameter int SELW       = 3
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic [NREG_BITS-1:0] id_rs,
  input  logic [NREG_BITS-1:0] id_rt,
  input  logic                 id_use_rs,
  input  logic                 id_use_rt,
  input  logic                 id_wreg,
  input  logic [NREG_BITS-1:0] id_rn,
  input  logic                 id_m2reg,
  input  logic                 id_md,
  input  logic                 id_branch_taken,
  output logic                 stall,
  output logic                 if_flush,
  output logic [SELW-1:0]      fwda,
  output logic [SELW-1:0]      fwdb,
  output logic                 md_busy,
  output logic                 md_done
`ifdef PIPE_HZD_STATS_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          fwd_cnt
`endif
);

  // Shadow pipeline: valid, destination register and load flag per stage.
  logic [FWD_DEPTH:1]   v_q;
  logic [FWD_DEPTH:1]   ld_q;
  logic [NREG_BITS-1:0] rn_q [1:FWD_DEPTH];

  // Mul/div scoreboard: remaining busy cycles and the pending destination.
  logic [3:0]           md_cnt_q;
  logic [3:0]           md_cnt_d;
  logic [NREG_BITS-1:0] md_rn_q;
  logic [NREG_BITS-1:0] md_rn_d;

  logic [SELW-1:0]      sel_a;
  logic [SELW-1:0]      sel_b;
  logic                 ldhz_a;
  logic                 ldhz_b;
  logic                 ld_stall;
  logic                 md_stall;
  logic                 md_start;
  logic                 md_reads;
  logic                 md_waw;

  // Youngest matching stage per operand; a too-young load becomes a hazard.
  // Scanning oldest-to-youngest lets the lowest stage index overwrite.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    ldhz_a = 1'b0;
    ldhz_b = 1'b0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (v_q[k] && id_use_rs && (id_rs != '0) && (rn_q[k] == id_rs)) begin
        sel_a  = SELW'(k);
        ldhz_a = ld_q[k] && (k < LOAD_STAGE);
      end
      if (v_q[k] && id_use_rt && (id_rt != '0) && (rn_q[k] == id_rt)) begin
        sel_b  = SELW'(k);
        ldhz_b = ld_q[k] && (k < LOAD_STAGE);
      end
    end
  end

  // A load-use hazard on an operand suppresses that operand's forward select;
  // the instruction is held in ID and re-evaluated next cycle anyway.
  assign fwda = ldhz_a ? '0 : sel_a;
  assign fwdb = ldhz_b ? '0 : sel_b;

  assign ld_stall = ldhz_a | ldhz_b;

  // While a mul/div is pending, block a second mul/div, readers of its
  // destination (register 0 is never a real dependency) and writers that
  // would be overtaken by the late mul/div write-back.
  assign md_busy  = (md_cnt_q != 4'd0);
  assign md_reads = (md_rn_q != '0) &&
                    ((id_use_rs && (id_rs == md_rn_q)) ||
                     (id_use_rt && (id_rt == md_rn_q)));
  assign md_waw   = id_wreg && (id_rn == md_rn_q);
  assign md_stall = md_busy && (id_md || md_reads || md_waw);

  assign stall    = ld_stall | md_stall;
  assign if_flush = id_branch_taken & ~stall;

  // The result is written in the last busy cycle; a reset in that cycle
  // abandons the operation, so the pulse is suppressed.
  assign md_done  = clrn && (md_cnt_q == 4'd1);

  assign md_start = id_md & ~stall & ~md_busy;

  // Scoreboard next state: load on start, otherwise count down to idle.
  always_comb begin
    md_cnt_d = md_cnt_q;
    md_rn_d  = md_rn_q;
    if (md_start) begin
      md_cnt_d = 4'(MD_LATENCY);
      md_rn_d  = id_rn;
    end else if (md_busy) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end
  end

  // Control state: stage valids shift every cycle, stall injects a bubble.
  // A mul/div is tracked by the scoreboard, not by the shadow pipeline.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      v_q      <= '0;
      md_cnt_q <= 4'd0;
      md_rn_q  <= '0;
    end else begin
      v_q[1] <= id_wreg & ~id_md & ~stall;
      for (int k = 2; k <= FWD_DEPTH; k++) begin
        v_q[k] <= v_q[k-1];
      end
      md_cnt_q <= md_cnt_d;
      md_rn_q  <= md_rn_d;
    end
  end

  // Tag payload shifts alongside the valids; it is only consulted when valid.
  always_ff @(posedge clk) begin
    rn_q[1] <= id_rn;
    ld_q[1] <= id_m2reg;
    for (int k = 2; k <= FWD_DEPTH; k++) begin
      rn_q[k] <= rn_q[k-1];
      ld_q[k] <= ld_q[k-1];
    end
  end

`ifdef PIPE_HZD_STATS_EN
  // Event counters for stall cycles and cycles with any active forward.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      stall_cnt <= 32'd0;
      fwd_cnt   <= 32'd0;
    end else begin
      if (stall) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if ((fwda != '0) || (fwdb != '0)) begin
        fwd_cnt <= fwd_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_fwd_unit.sv
// Directed self-checking bench for pipe_hazard_fwd_unit. A default instance
// and a LOAD_STAGE=3 instance share one stimulus stream.
module tb_pipe_hazard_fwd_unit;

  logic       clk = 1'b0;
  logic       clrn;
  logic [4:0] id_rs, id_rt, id_rn;
  logic       id_use_rs, id_use_rt, id_wreg, id_m2reg, id_md, id_branch_taken;

  logic       stall, if_flush, md_busy, md_done;
  logic [2:0] fwda, fwdb;
  logic       stall3, if_flush3, md_busy3, md_done3;
  logic [2:0] fwda3, fwdb3;
`ifdef PIPE_HZD_STATS_EN
  logic [31:0] stall_cnt, fwd_cnt, stall_cnt3, fwd_cnt3;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_hazard_fwd_unit dut (
    .clk(clk), .clrn(clrn),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wreg(id_wreg), .id_rn(id_rn), .id_m2reg(id_m2reg), .id_md(id_md),
    .id_branch_taken(id_branch_taken),
    .stall(stall), .if_flush(if_flush), .fwda(fwda), .fwdb(fwdb),
    .md_busy(md_busy), .md_done(md_done)
`ifdef PIPE_HZD_STATS_EN
    , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
  );

  pipe_hazard_fwd_unit #(.LOAD_STAGE(3)) dut3 (
    .clk(clk), .clrn(clrn),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wreg(id_wreg), .id_rn(id_rn), .id_m2reg(id_m2reg), .id_md(id_md),
    .id_branch_taken(id_branch_taken),
    .stall(stall3), .if_flush(if_flush3), .fwda(fwda3), .fwdb(fwdb3),
    .md_busy(md_busy3), .md_done(md_done3)
`ifdef PIPE_HZD_STATS_EN
    , .stall_cnt(stall_cnt3), .fwd_cnt(fwd_cnt3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_rn = 5'd0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; id_wreg = 1'b0;
    id_m2reg = 1'b0; id_md = 1'b0; id_branch_taken = 1'b0;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) begin
      idle(); settle(); tick();
    end
  endtask

  initial begin
    clrn = 1'b0;
    idle();
    tick(); tick();
    clrn = 1'b1;
    settle();
    chk("rst_stall", 32'(stall), 0);
    chk("rst_flush", 32'(if_flush), 0);
    chk("rst_fwda", 32'(fwda), 0);
    chk("rst_fwdb", 32'(fwdb), 0);
    chk("rst_busy", 32'(md_busy), 0);
    chk("rst_done", 32'(md_done), 0);
    tick();

    // ALU chain: add $3, then readers of $3 at distance 1..4
    idle(); id_wreg = 1'b1; id_rn = 5'd3; settle(); tick();
    idle(); id_rs = 5'd3; id_use_rs = 1'b1; id_rt = 5'd5; id_use_rt = 1'b1;
    id_wreg = 1'b1; id_rn = 5'd4; settle();
    chk("chain_fwda1", 32'(fwda), 1);
    chk("chain_fwdb1", 32'(fwdb), 0);
    chk("chain_stall1", 32'(stall), 0);
    chk("chain3_fwda1", 32'(fwda3), 1);
    tick();
    idle(); id_rs = 5'd3; id_use_rs = 1'b1; settle();
    chk("chain_fwda2", 32'(fwda), 2); tick();
    idle(); id_rs = 5'd3; id_use_rs = 1'b1; settle();
    chk("chain_fwda3", 32'(fwda), 3); tick();
    idle(); id_rs = 5'd3; id_use_rs = 1'b1; settle();
    chk("chain_fwda4", 32'(fwda), 0); tick();
    flush();

    // Load-use: lw $3; add $4,$3,$3 held in ID while stalled
    idle(); id_wreg = 1'b1; id_rn = 5'd3; id_m2reg = 1'b1; settle(); tick();
    idle(); id_rs = 5'd3; id_rt = 5'd3; id_use_rs = 1'b1; id_use_rt = 1'b1;
    id_wreg = 1'b1; id_rn = 5'd4; settle();
    chk("lu_stall_c1", 32'(stall), 1);
    chk("lu_fwda_c1", 32'(fwda), 0);
    chk("lu_fwdb_c1", 32'(fwdb), 0);
    chk("lu3_stall_c1", 32'(stall3), 1);
    tick();
    settle();
    chk("lu_stall_c2", 32'(stall), 0);
    chk("lu_fwda_c2", 32'(fwda), 2);
    chk("lu_fwdb_c2", 32'(fwdb), 2);
    chk("lu3_stall_c2", 32'(stall3), 1);
    chk("lu3_fwda_c2", 32'(fwda3), 0);
    tick();
    settle();
    chk("lu3_stall_c3", 32'(stall3), 0);
    chk("lu3_fwda_c3", 32'(fwda3), 3);
    chk("lu3_fwdb_c3", 32'(fwdb3), 3);
    tick();
    flush();

    // Register 0 never matches, even for a load; youngest of two writers wins
    idle(); id_wreg = 1'b1; id_rn = 5'd0; settle(); tick();
    idle(); id_wreg = 1'b1; id_rn = 5'd0; id_m2reg = 1'b1; settle(); tick();
    idle(); id_use_rs = 1'b1; id_use_rt = 1'b1; settle();
    chk("r0_fwda", 32'(fwda), 0);
    chk("r0_fwdb", 32'(fwdb), 0);
    chk("r0_stall", 32'(stall), 0);
    tick();
    idle(); id_wreg = 1'b1; id_rn = 5'd7; settle(); tick();
    idle(); id_wreg = 1'b1; id_rn = 5'd7; settle(); tick();
    idle(); id_rs = 5'd7; id_use_rs = 1'b1; id_rt = 5'd7; settle();
    chk("young_fwda", 32'(fwda), 1);
    chk("nouse_fwdb", 32'(fwdb), 0);
    tick();
    flush();

    // mul $8 then a reader of $8: four stall cycles, done on the fourth
    idle(); id_md = 1'b1; id_wreg = 1'b1; id_rn = 5'd8; settle();
    chk("md_idle_busy", 32'(md_busy), 0);
    chk("md_start_stall", 32'(stall), 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      idle(); id_rs = 5'd8; id_use_rs = 1'b1; settle();
      chk("md_raw_stall", 32'(stall), 1);
      chk("md_raw_busy", 32'(md_busy), 1);
      chk("md_raw_done", 32'(md_done), (i == 3) ? 1 : 0);
      chk("md_raw_fwda", 32'(fwda), 0);
      tick();
    end
    idle(); id_rs = 5'd8; id_use_rs = 1'b1; settle();
    chk("md_after_stall", 32'(stall), 0);
    chk("md_after_busy", 32'(md_busy), 0);
    chk("md_after_done", 32'(md_done), 0);
    tick();
    idle(); id_md = 1'b1; id_wreg = 1'b1; id_rn = 5'd9; settle();
    chk("md2_start_stall", 32'(stall), 0); tick();
    idle(); id_md = 1'b1; id_wreg = 1'b1; id_rn = 5'd10; settle();
    chk("md_struct_stall", 32'(stall), 1); tick();
    idle(); id_wreg = 1'b1; id_rn = 5'd9; settle();
    chk("md_waw_stall", 32'(stall), 1); tick();
    idle(); settle();
    chk("md_free_stall", 32'(stall), 0);
    chk("md_free_busy", 32'(md_busy), 1);
    chk("md_free_done", 32'(md_done), 0);
    tick();
    idle(); settle();
    chk("md2_done", 32'(md_done), 1); tick();
    idle(); settle();
    chk("md2_idle", 32'(md_busy), 0); tick();
    flush();

    // Branches: clean taken branch flushes; one waiting on a load is delayed
    idle(); id_branch_taken = 1'b1; settle();
    chk("br_flush", 32'(if_flush), 1);
    chk("br_stall", 32'(stall), 0);
    tick();
    idle(); settle();
    chk("br_noflush", 32'(if_flush), 0); tick();
    idle(); id_wreg = 1'b1; id_rn = 5'd6; id_m2reg = 1'b1; settle(); tick();
    idle(); id_rs = 5'd6; id_use_rs = 1'b1; id_branch_taken = 1'b1; settle();
    chk("brlu_stall", 32'(stall), 1);
    chk("brlu_flush", 32'(if_flush), 0);
    tick();
    settle();
    chk("brlu_stall2", 32'(stall), 0);
    chk("brlu_flush2", 32'(if_flush), 1);
    chk("brlu_fwda2", 32'(fwda), 2);
    tick();
    flush();

    // Reset during an md busy period and a load-use stall
    idle(); id_md = 1'b1; id_wreg = 1'b1; id_rn = 5'd8; settle(); tick();
    idle(); id_wreg = 1'b1; id_rn = 5'd5; id_m2reg = 1'b1; settle();
    chk("mr_load_stall", 32'(stall), 0); tick();
    idle(); id_rs = 5'd5; id_use_rs = 1'b1; settle();
    chk("mr_pre_stall", 32'(stall), 1);
    chk("mr_pre_busy", 32'(md_busy), 1);
    clrn = 1'b0;
    tick();
    clrn = 1'b1;
    settle();
    chk("mr_stall", 32'(stall), 0);
    chk("mr_fwda", 32'(fwda), 0);
    chk("mr_busy", 32'(md_busy), 0);
    chk("mr_done", 32'(md_done), 0);
    chk("mr_flush", 32'(if_flush), 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      idle(); settle();
      chk("mr_nodone", 32'(md_done), 0);
      tick();
    end

    // Three stall cycles and two forwarding cycles since the reset
    idle(); id_wreg = 1'b1; id_rn = 5'd3; id_m2reg = 1'b1; settle(); tick();
    idle(); id_rs = 5'd3; id_use_rs = 1'b1; settle();
    chk("st_lu_stall", 32'(stall), 1); tick();
    settle();
    chk("st_lu_fwda", 32'(fwda), 2); tick();
    idle(); id_md = 1'b1; id_wreg = 1'b1; id_rn = 5'd9; settle();
    chk("st_md_start", 32'(stall), 0); tick();
    for (int i = 0; i < 2; i++) begin
      idle(); id_rs = 5'd9; id_use_rs = 1'b1; settle();
      chk("st_md_stall", 32'(stall), 1); tick();
    end
    idle(); settle(); tick();
    idle(); id_wreg = 1'b1; id_rn = 5'd2; settle(); tick();
    idle(); id_rs = 5'd2; id_use_rs = 1'b1; settle();
    chk("st_fwda", 32'(fwda), 1); tick();
    idle(); settle();
`ifdef PIPE_HZD_STATS_EN
    chk("stall_cnt", stall_cnt, 3);
    chk("fwd_cnt", fwd_cnt, 2);
`endif
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
